// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared constants, command codes and FSM encoding for the AD5681R SPI receiver
package dac_spi_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CODE_MSB   = 19;
    localparam int CODE_LSB   = 8;
    localparam int CMD_MSB    = 23;
    localparam int CMD_LSB    = 20;
    localparam int CODE_W     = CODE_MSB - CODE_LSB + 1;

    // Bit counter must hold FRAME_BITS + 1 so an over-long frame is distinguishable
    localparam int                CNT_W    = 5;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    localparam logic [3:0] CMD_WR_IN  = 4'h1;
    localparam logic [3:0] CMD_UPD    = 4'h2;
    localparam logic [3:0] CMD_WR_UPD = 4'h3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ad5681r_spi_receiver_if.sv
// rtl/ad5681r_spi_receiver_if.sv - DAC pin side and decoded-frame outputs of the SPI receiver
interface ad5681r_spi_receiver_if;
    import dac_spi_pkg::*;

    logic                  sclk;
    logic                  sdin;
    logic                  sync_n;
    logic                  ldac_n;
    logic [FRAME_BITS-1:0] frame_data;
    logic [3:0]            frame_cmd;
    logic                  frame_valid;
    logic                  frame_err;
    logic [CODE_W-1:0]     input_reg;
    logic [CODE_W-1:0]     dac_code;

    // SPI master side: drives the pins, observes the DAC model
    modport master (
        output sclk, sdin, sync_n, ldac_n,
        input  frame_data, frame_cmd, frame_valid, frame_err, input_reg, dac_code
    );

    // DAC model side
    modport slave (
        input  sclk, sdin, sync_n, ldac_n,
        output frame_data, frame_cmd, frame_valid, frame_err, input_reg, dac_code
    );

endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop pin synchroniser with registered rise/fall pulses
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic       s1_q;
    logic       s2_q;
    logic       hist_q;
    logic       rise_q;
    logic       fall_q;
    // Edges are suppressed until s1/s2/hist all hold real pin samples, so a pin
    // sitting at the opposite of RESET_VAL out of reset does not fake an edge.
    logic [2:0] prime_q;

    // Synchroniser chain, history flop and registered edge pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            hist_q  <= RESET_VAL;
            prime_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            hist_q  <= s2_q;
            prime_q <= {prime_q[1:0], 1'b1};
            rise_q  <= prime_q[2] &  s2_q & ~hist_q;
            fall_q  <= prime_q[2] & ~s2_q &  hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ad5681r_spi_receiver.sv
// rtl/ad5681r_spi_receiver.sv - oversampling AD5681R serial-port model: deserialiser, decoder, DAC registers
module ad5681r_spi_receiver
    import dac_spi_pkg::*;
#(
    parameter bit SAMPLE_FALL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ad5681r_spi_receiver_if.slave   bus
);

    logic sclk_rise;
    logic sclk_fall;
    logic sync_rise;
    logic sync_fall;
    logic ldac_fall;
    logic ldac_rise_unused;
    logic sample;

    // sdin gets a third flop so it lines up with the registered edge pulses
    logic sdin_s1_q;
    logic sdin_s2_q;
    logic sdin_s3_q;

    state_e                state_q,       state_d;
    logic [FRAME_BITS-1:0] shreg_q,       shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic [FRAME_BITS-1:0] frame_data_q,  frame_data_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q,   frame_err_d;
    logic [CODE_W-1:0]     input_reg_q,   input_reg_d;
    logic [CODE_W-1:0]     dac_code_q,    dac_code_d;

    logic [3:0]            cmd;
    logic [CODE_W-1:0]     code;

    sync_edge_det #(.RESET_VAL(1'b0)) u_sclk_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (bus.sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b1)) u_sync_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (bus.sync_n),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b1)) u_ldac_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (bus.ldac_n),
        .rise_o (ldac_rise_unused),
        .fall_o (ldac_fall)
    );

    assign sample = SAMPLE_FALL ? sclk_fall : sclk_rise;

    // Data pin synchroniser, delay-matched to the edge detectors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdin_s1_q <= 1'b0;
            sdin_s2_q <= 1'b0;
            sdin_s3_q <= 1'b0;
        end else begin
            sdin_s1_q <= bus.sdin;
            sdin_s2_q <= sdin_s1_q;
            sdin_s3_q <= sdin_s2_q;
        end
    end

    // FSM state and frame datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Next state: a frame opens on a sync_n fall and closes on a sync_n rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sync_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (sync_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: shifting, bit counting and end-of-frame verdict; sync_n rise beats a sample edge
    always_comb begin
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_fall) begin
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (sync_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        frame_valid_d = 1'b1;
                        frame_data_d  = shreg_q;
                    end else begin
                        frame_err_d   = 1'b1;
                    end
                end else if (sample) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], sdin_s3_q};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign cmd  = frame_data_q[CMD_MSB:CMD_LSB];
    assign code = frame_data_q[CODE_MSB:CODE_LSB];

    // Register file next state: LDAC first so a coincident frame command overrides it
    always_comb begin
        input_reg_d = input_reg_q;
        dac_code_d  = dac_code_q;
        if (ldac_fall) begin
            dac_code_d = input_reg_q;
        end
        if (frame_valid_q) begin
            case (cmd)
                CMD_WR_IN:  input_reg_d = code;
                CMD_UPD:    dac_code_d  = input_reg_q;
                CMD_WR_UPD: begin
                    input_reg_d = code;
                    dac_code_d  = code;
                end
                default: ;
            endcase
        end
    end

    // Input and DAC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            input_reg_q <= '0;
            dac_code_q  <= '0;
        end else begin
            input_reg_q <= input_reg_d;
            dac_code_q  <= dac_code_d;
        end
    end

    assign bus.frame_data  = frame_data_q;
    assign bus.frame_cmd   = cmd;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.input_reg   = input_reg_q;
    assign bus.dac_code    = dac_code_q;

endmodule

// File: tb/tb_ad5681r_spi_receiver.sv
// tb/tb_ad5681r_spi_receiver.sv - directed bench driving falling- and rising-edge receivers from shared pins
module tb_ad5681r_spi_receiver;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk;
    logic sdin;
    logic sync_n;
    logic ldac_n;

    int n_checks = 0;
    int n_errors = 0;

    int vf = 0, ef = 0, vr = 0, er = 0;
    int vf0 = 0, ef0 = 0, vr0 = 0, er0 = 0;
    int lat_f = 0, lat_r = 0;

    ad5681r_spi_receiver_if bus_f ();
    ad5681r_spi_receiver_if bus_r ();

    assign bus_f.sclk   = sclk;
    assign bus_f.sdin   = sdin;
    assign bus_f.sync_n = sync_n;
    assign bus_f.ldac_n = ldac_n;
    assign bus_r.sclk   = sclk;
    assign bus_r.sdin   = sdin;
    assign bus_r.sync_n = sync_n;
    assign bus_r.ldac_n = ldac_n;

    ad5681r_spi_receiver #(.SAMPLE_FALL(1'b1)) u_dut_fall (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    ad5681r_spi_receiver #(.SAMPLE_FALL(1'b0)) u_dut_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus_f.frame_valid) vf++;
        if (bus_f.frame_err)   ef++;
        if (bus_r.frame_valid) vr++;
        if (bus_r.frame_err)   er++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag,
                              input logic [23:0] fd_f, input logic [11:0] in_f, input logic [11:0] dac_f,
                              input logic [23:0] fd_r, input logic [11:0] in_r, input logic [11:0] dac_r);
        check_eq({tag, "/data_f"}, 32'(bus_f.frame_data), 32'(fd_f));
        check_eq({tag, "/cmd_f"},  32'(bus_f.frame_cmd),  32'(fd_f[23:20]));
        check_eq({tag, "/in_f"},   32'(bus_f.input_reg),  32'(in_f));
        check_eq({tag, "/dac_f"},  32'(bus_f.dac_code),   32'(dac_f));
        check_eq({tag, "/data_r"}, 32'(bus_r.frame_data), 32'(fd_r));
        check_eq({tag, "/cmd_r"},  32'(bus_r.frame_cmd),  32'(fd_r[23:20]));
        check_eq({tag, "/in_r"},   32'(bus_r.input_reg),  32'(in_r));
        check_eq({tag, "/dac_r"},  32'(bus_r.dac_code),   32'(dac_r));
    endtask

    // Pulse counts since the previous call
    task automatic expect_pulses(input string tag, input int dvf, input int def, input int dvr, input int der);
        check_eq({tag, "/nvalid_f"}, 32'(vf - vf0), 32'(dvf));
        check_eq({tag, "/nerr_f"},   32'(ef - ef0), 32'(def));
        check_eq({tag, "/nvalid_r"}, 32'(vr - vr0), 32'(dvr));
        check_eq({tag, "/nerr_r"},   32'(er - er0), 32'(der));
        vf0 = vf; ef0 = ef; vr0 = vr; er0 = er;
    endtask

    // word[31] is sent first. mode 0: normal close, 1: sync_n rise with an SCLK rise,
    // 2: sync_n rise with an SCLK fall, 3: leave the frame open
    task automatic send_frame(input logic [31:0] word, input int nbits, input int ph, input int mode);
        sclk   = 1'b0;
        sync_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sdin = word[31-i];
            tick(ph);
            sclk = 1'b1;
            tick(ph);
            sclk = 1'b0;
            tick(1);
        end
        case (mode)
            0: begin
                sync_n = 1'b1;
                lat_f = 0;
                lat_r = 0;
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (bus_f.frame_valid && lat_f == 0) lat_f = k;
                    if (bus_r.frame_valid && lat_r == 0) lat_r = k;
                end
            end
            1: begin
                sdin = 1'b0;
                tick(ph);
                sclk   = 1'b1;
                sync_n = 1'b1;
                tick(ph);
                sclk = 1'b0;
            end
            2: begin
                sdin = 1'b0;
                tick(ph);
                sclk = 1'b1;
                tick(ph);
                sclk   = 1'b0;
                sync_n = 1'b1;
            end
            default: ;
        endcase
        if (mode != 3) tick(10);
    endtask

    initial begin
        rst_n  = 1'b0;
        sclk   = 1'b0;
        sdin   = 1'b0;
        sync_n = 1'b1;
        ldac_n = 1'b1;
        tick(4);
        check_eq("rst/valid_f", 32'(bus_f.frame_valid), 32'd0);
        check_eq("rst/err_f",   32'(bus_f.frame_err),   32'd0);
        check_eq("rst/valid_r", 32'(bus_r.frame_valid), 32'd0);
        check_eq("rst/err_r",   32'(bus_r.frame_err),   32'd0);
        rst_n = 1'b1;
        tick(6);
        expect_out("rst", 24'h0, 12'h0, 12'h0, 24'h0, 12'h0, 12'h0);
        expect_pulses("rst", 0, 0, 0, 0);

        send_frame({24'h300000, 8'h00}, 24, 4, 0);
        check_eq("t1/lat_f", 32'(lat_f), 32'd4);
        check_eq("t1/lat_r", 32'(lat_r), 32'd4);
        expect_out("t1", 24'h300000, 12'h000, 12'h000, 24'h300000, 12'h000, 12'h000);
        expect_pulses("t1", 1, 0, 1, 0);

        send_frame({24'h38ff00, 8'h00}, 24, 4, 0);
        expect_out("t2a", 24'h38ff00, 12'h8ff, 12'h8ff, 24'h38ff00, 12'h8ff, 12'h8ff);
        send_frame({24'h3fff00, 8'h00}, 24, 4, 0);
        expect_out("t2b", 24'h3fff00, 12'hfff, 12'hfff, 24'h3fff00, 12'hfff, 12'hfff);
        expect_pulses("t2", 2, 0, 2, 0);

        send_frame({24'h1abc00, 8'h00}, 24, 4, 0);
        expect_out("t3", 24'h1abc00, 12'habc, 12'hfff, 24'h1abc00, 12'habc, 12'hfff);
        ldac_n = 1'b0;
        tick(4);
        ldac_n = 1'b1;
        tick(8);
        expect_out("ldac", 24'h1abc00, 12'habc, 12'habc, 24'h1abc00, 12'habc, 12'habc);
        expect_pulses("t3", 1, 0, 1, 0);

        send_frame({24'h0f0f00, 8'h00}, 24, 4, 0);
        expect_out("cmd0", 24'h0f0f00, 12'habc, 12'habc, 24'h0f0f00, 12'habc, 12'habc);
        send_frame({24'h112300, 8'h00}, 24, 4, 0);
        send_frame({24'h200000, 8'h00}, 24, 4, 0);
        expect_out("cmd2", 24'h200000, 12'h123, 12'h123, 24'h200000, 12'h123, 12'h123);
        expect_pulses("cmds", 3, 0, 3, 0);

        send_frame({24'h155500, 8'h00}, 16, 4, 0);
        expect_out("short", 24'h200000, 12'h123, 12'h123, 24'h200000, 12'h123, 12'h123);
        expect_pulses("short", 0, 1, 0, 1);
        send_frame({24'h177700, 8'h80}, 25, 4, 0);
        expect_out("long", 24'h200000, 12'h123, 12'h123, 24'h200000, 12'h123, 12'h123);
        expect_pulses("long", 0, 1, 0, 1);

        send_frame({24'h340000, 8'h00}, 10, 4, 3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        expect_out("midrst", 24'h0, 12'h0, 12'h0, 24'h0, 12'h0, 12'h0);
        sync_n = 1'b1;
        tick(10);
        expect_pulses("midrst", 0, 0, 0, 0);
        send_frame({24'h340000, 8'h00}, 24, 4, 0);
        expect_out("after_rst", 24'h340000, 12'h400, 12'h400, 24'h340000, 12'h400, 12'h400);
        expect_pulses("after_rst", 1, 0, 1, 0);

        send_frame({24'h3aaa00, 8'h00}, 24, 3, 1);
        expect_out("co_rise", 24'h3aaa00, 12'haaa, 12'haaa, 24'h3aaa00, 12'haaa, 12'haaa);
        expect_pulses("co_rise", 1, 0, 1, 0);
        send_frame({24'h355500, 8'h00}, 24, 3, 2);
        expect_out("co_fall", 24'h355500, 12'h555, 12'h555, 24'h3aaa00, 12'haaa, 12'haaa);
        expect_pulses("co_fall", 1, 0, 0, 1);
        send_frame({24'h1abc00, 8'h00}, 24, 3, 0);
        expect_out("ph3", 24'h1abc00, 12'habc, 12'h555, 24'h1abc00, 12'habc, 12'haaa);
        expect_pulses("ph3", 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
